// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin arbiter that shares one WIDTH-bit,
// 8-operation logic unit between NREQ requesters. Each transaction is
// captured in IDLE, computed in EXEC and held in RESP until accepted.
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy,
  output logic [15:0]           ops_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_XOR  = 3'b001,
    OP_NAND = 3'b010,
    OP_OR   = 3'b011,
    OP_NOTA = 3'b100,
    OP_NOR  = 3'b101,
    OP_NEGA = 3'b110,
    OP_XNOR = 3'b111
  } op_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [15:0]       ops_done_q, ops_done_d;

  logic [2*NREQ-1:0] valid_dbl;
  logic [2*NREQ-1:0] valid_rot;
  logic [ID_W:0]     grant_sum;
  logic [ID_W-1:0]   grant;
  logic              grant_found;
  logic              accept;
  logic [2:0]        sel_op;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic [WIDTH-1:0]  alu_res;

  // Round-robin search: rotate the valid vector so rr_ptr sits at bit 0,
  // take the first set bit, then map the offset back to a requester index.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    valid_dbl   = {req_valid, req_valid};
    valid_rot   = valid_dbl >> rr_ptr_q;
    grant_found = 1'b0;
    grant_sum   = '0;
    grant       = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && valid_rot[k]) begin
        grant_found = 1'b1;
        grant_sum   = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      end
    end
    if (grant_sum >= (ID_W+1)'(NREQ)) begin
      grant_sum = grant_sum - (ID_W+1)'(NREQ);
    end
    grant = grant_sum[ID_W-1:0];
  end

  // Only the granted requester sees ready, and only in IDLE out of reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == ST_IDLE) && grant_found) begin
      req_ready = NREQ'(1) << grant;
    end
  end

  assign accept = rst_n && (state_q == ST_IDLE) && grant_found;

  // Operand mux: pick the granted requester's opcode and operands.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == grant) begin
        sel_op = req_op[3*k +: 3];
        sel_a  = req_a[WIDTH*k +: WIDTH];
        sel_b  = req_b[WIDTH*k +: WIDTH];
      end
    end
  end

  // Logic unit operating on the captured operands.
  always_comb begin
    alu_res = '0;
    case (op_e'(op_q))
      OP_AND:  alu_res = a_q & b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NAND: alu_res = ~(a_q & b_q);
      OP_OR:   alu_res = a_q | b_q;
      OP_NOTA: alu_res = ~a_q;
      OP_NOR:  alu_res = ~(a_q | b_q);
      OP_NEGA: alu_res = '0 - a_q;
      OP_XNOR: alu_res = ~(a_q ^ b_q);
      default: alu_res = '0;
    endcase
  end

  // Next-state and register-update logic for the three-state transaction FSM.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    ops_done_d  = ops_done_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          grant_d = grant;
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = alu_res;
        rsp_id_d    = grant_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 16'd1;
          rr_ptr_d    = (grant_q == ID_W'(NREQ-1)) ? '0 : grant_q + ID_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-low reset that clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      ops_done_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values,
      // independent of statement order.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign ops_done  = ops_done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed testbench for logic_unit_arbiter: opcode table, round-robin
// order, backpressure, operand stability, mid-operation reset, edge ops.
module tb_logic_unit_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int ID_W  = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;
  logic [15:0]           ops_done;

  int          checks;
  int          failures;
  logic [15:0] exp_ops;

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with rsp_ready high. Starts and ends 1 unit after
  // an edge with the DUT in IDLE and no other requester valid.
  task automatic run_txn(input int id, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_data, input string name);
    rsp_ready = 1'b1;
    req_valid = NREQ'(1) << id;
    req_op[3*id +: 3]         = op;
    req_a[WIDTH*id +: WIDTH]  = a;
    req_b[WIDTH*id +: WIDTH]  = b;
    #1;
    checks++;
    if (req_ready !== (NREQ'(1) << id)) begin
      failures++; $display("FAIL %s req_ready got=%b exp=%b", name, req_ready, NREQ'(1) << id);
    end
    tick();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL %s exec_cycle rsp_valid=%b busy=%b exp 0/1", name, rsp_valid, busy);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_id !== ID_W'(id)) begin
      failures++;
      $display("FAIL %s rsp valid=%b data=%h id=%0d exp valid=1 data=%h id=%0d",
               name, rsp_valid, rsp_data, rsp_id, exp_data, id);
    end
    tick();
    exp_ops = exp_ops + 16'd1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== exp_ops) begin
      failures++;
      $display("FAIL %s after_hs rsp_valid=%b busy=%b ops_done=%h exp 0/0/%h",
               name, rsp_valid, busy, ops_done, exp_ops);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    req_op = '0; req_a = '0; req_b = '0;
    tick();
    checks++;
    if (req_ready !== '0) begin
      failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    exp_ops = 16'd0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd0 ||
        rsp_id !== '0 || rsp_data !== '0) begin
      failures++;
      $display("FAIL reset_state valid=%b busy=%b ops=%h id=%0d data=%h exp all zero",
               rsp_valid, busy, ops_done, rsp_id, rsp_data);
    end
    tick();
  endtask

  task automatic test_opcodes();
    logic [WIDTH-1:0] exp_tab [8];
    exp_tab[0] = 32'h0000_0098; exp_tab[1] = 32'h0000_0067;
    exp_tab[2] = 32'hFFFF_FF67; exp_tab[3] = 32'h0000_00FF;
    exp_tab[4] = 32'hFFFF_FF24; exp_tab[5] = 32'hFFFF_FF00;
    exp_tab[6] = 32'hFFFF_FF25; exp_tab[7] = 32'hFFFF_FF98;
    for (int op = 0; op < 8; op++) begin
      run_txn(0, 3'(op), 32'h0000_00DB, 32'h0000_00BC, exp_tab[op], $sformatf("op%0d", op));
    end
    checks++;
    if (ops_done !== 16'd8) begin
      failures++; $display("FAIL opcodes_count ops_done=%0d exp=8", ops_done);
    end
  endtask

  task automatic test_round_robin();
    int g;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_op[3*i +: 3]        = 3'b011;
      req_a[WIDTH*i +: WIDTH] = WIDTH'(i);
      req_b[WIDTH*i +: WIDTH] = 32'h10;
    end
    req_valid = '1;
    tick();
    rst_n = 1'b1;
    exp_ops = 16'd0;
    for (int t = 0; t < 8; t++) begin
      g = t % NREQ;
      #1;
      checks++;
      if (req_ready !== (NREQ'(1) << g)) begin
        failures++; $display("FAIL rr_grant t=%0d req_ready=%b exp=%b", t, req_ready, NREQ'(1) << g);
      end
      tick();
      checks++;
      if (req_ready !== '0 || busy !== 1'b1) begin
        failures++; $display("FAIL rr_exec t=%0d req_ready=%b busy=%b exp 0000/1", t, req_ready, busy);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(g) ||
          rsp_data !== (32'h10 | WIDTH'(g)) || req_ready !== '0) begin
        failures++;
        $display("FAIL rr_rsp t=%0d valid=%b id=%0d data=%h ready=%b exp 1/%0d/%h/0000",
                 t, rsp_valid, rsp_id, rsp_data, req_ready, g, 32'h10 | WIDTH'(g));
      end
      tick();
      exp_ops = exp_ops + 16'd1;
    end
    req_valid = '0;
    checks++;
    if (ops_done !== 16'd8) begin
      failures++; $display("FAIL rr_count ops_done=%0d exp=8", ops_done);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] exp_d;
    exp_d = 32'hF0F0_F0F0 & 32'hFF00_FF00;
    rsp_ready = 1'b0;
    req_op[2:0] = 3'b000;
    req_a[WIDTH-1:0] = 32'hF0F0_F0F0;
    req_b[WIDTH-1:0] = 32'hFF00_FF00;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 2'd0 ||
          busy !== 1'b1 || req_ready !== '0) begin
        failures++;
        $display("FAIL bp_hold c=%0d valid=%b data=%h id=%0d busy=%b ready=%b exp 1/%h/0/1/0000",
                 c, rsp_valid, rsp_data, rsp_id, busy, req_ready, exp_d);
      end
      if (c < 4) tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0) begin
      failures++; $display("FAIL bp_hs_ready req_ready=%b exp=0000", req_ready);
    end
    tick();
    req_valid = '0;
    exp_ops = exp_ops + 16'd1;
    checks++;
    if (rsp_valid !== 1'b0 || ops_done !== exp_ops || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_after valid=%b ops=%0d busy=%b exp 0/%0d/0", rsp_valid, ops_done, busy, exp_ops);
    end
    tick();
    checks++;
    if (ops_done !== exp_ops) begin
      failures++; $display("FAIL bp_once ops=%0d exp=%0d", ops_done, exp_ops);
    end
  endtask

  task automatic test_operand_change();
    rsp_ready = 1'b1;
    req_op[3*2 +: 3] = 3'b100;
    req_a[WIDTH*2 +: WIDTH] = 32'hDEAD_BEEF;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    req_a[WIDTH*2 +: WIDTH] = 32'h0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h2152_4110 || rsp_id !== 2'd2) begin
      failures++;
      $display("FAIL opchg valid=%b data=%h id=%0d exp 1/21524110/2", rsp_valid, rsp_data, rsp_id);
    end
    tick();
    exp_ops = exp_ops + 16'd1;
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    req_op[3*3 +: 3] = 3'b000;
    req_a[WIDTH*3 +: WIDTH] = 32'h1234_5678;
    req_b[WIDTH*3 +: WIDTH] = 32'hFFFF_FFFF;
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin
      failures++; $display("FAIL rmid_pre valid=%b id=%0d exp 1/3", rsp_valid, rsp_id);
    end
    rst_n = 1'b0;
    req_valid = 4'b1010;
    req_op[3*1 +: 3] = 3'b011;
    req_a[WIDTH*1 +: WIDTH] = 32'h1;
    req_b[WIDTH*1 +: WIDTH] = 32'h10;
    req_op[3*3 +: 3] = 3'b011;
    #1;
    checks++;
    if (req_ready !== '0) begin
      failures++; $display("FAIL rmid_ready_in_reset req_ready=%b exp=0000", req_ready);
    end
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    exp_ops = 16'd0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd0) begin
      failures++;
      $display("FAIL rmid_state valid=%b busy=%b ops=%0d exp 0/0/0", rsp_valid, busy, ops_done);
    end
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL rmid_grant req_ready=%b exp=0010", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h11) begin
      failures++;
      $display("FAIL rmid_rsp valid=%b id=%0d data=%h exp 1/1/00000011", rsp_valid, rsp_id, rsp_data);
    end
    tick();
    exp_ops = exp_ops + 16'd1;
    checks++;
    if (ops_done !== exp_ops) begin
      failures++; $display("FAIL rmid_count ops=%0d exp=%0d", ops_done, exp_ops);
    end
  endtask

  task automatic test_edge_ops();
    run_txn(0, 3'b110, 32'h0000_0000, 32'h0, 32'h0000_0000, "neg_zero");
    run_txn(0, 3'b110, 32'h8000_0000, 32'h0, 32'h8000_0000, "neg_min");
    // Preload the counter just below wrap instead of running 65535 transactions.
    dut.ops_done_q = 16'hFFFF;
    exp_ops = 16'hFFFF;
    #1;
    checks++;
    if (ops_done !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_preload ops=%h exp=ffff", ops_done);
    end
    run_txn(1, 3'b011, 32'h0, 32'h5, 32'h5, "wrap_txn");
    checks++;
    if (ops_done !== 16'h0000) begin
      failures++; $display("FAIL wrap ops=%h exp=0000", ops_done);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_ops   = 16'd0;
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_opcodes();
    test_round_robin();
    test_backpressure();
    test_operand_change();
    test_reset_mid();
    test_edge_ops();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
